// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit sitting behind the EXE/MEM pipeline register.
// Runs the D-cache request/grant/ack handshake, lane-aligns store data and
// strobes, extends load data, raises Dstall and owns the MEM/WB register.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   Dcache_en, Dcache_write       EXE/MEM memory access strobe and store flag
//   D_address, Read_data_2_EXE_MEM, funct3_EXE_MEM
//                                 byte address, store source, access size/sign
//   alu_result_EXE_MEM, write_addr_EXE_MEM, WB_ctr_EXE_MEM
//                                 non-memory result, rd, writeback control
//   Istall                        instruction-side stall
//   dc_req/dc_write/dc_addr/dc_wdata/dc_wstrb   D-cache request (registered)
//   dc_gnt, dc_ack, dc_rdata      D-cache grant, completion, read word
//   Dstall                        hold upstream pipeline registers
//   misalign                      one-cycle pulse on a dropped misaligned access
//   wb_data_MEM_WB, write_addr_MEM_WB, WB_ctr_MEM_WB   MEM/WB register
module mem_stage_lsu #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Dcache_en,
    input  logic              Dcache_write,
    input  logic [DATA_W-1:0] D_address,
    input  logic [DATA_W-1:0] Read_data_2_EXE_MEM,
    input  logic [2:0]        funct3_EXE_MEM,
    input  logic [DATA_W-1:0] alu_result_EXE_MEM,
    input  logic [4:0]        write_addr_EXE_MEM,
    input  logic [2:0]        WB_ctr_EXE_MEM,
    input  logic              Istall,
    output logic              dc_req,
    output logic              dc_write,
    output logic [DATA_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [3:0]        dc_wstrb,
    input  logic              dc_gnt,
    input  logic              dc_ack,
    input  logic [DATA_W-1:0] dc_rdata,
    output logic              Dstall,
    output logic              misalign,
    output logic [DATA_W-1:0] wb_data_MEM_WB,
    output logic [4:0]        write_addr_MEM_WB,
    output logic [2:0]        WB_ctr_MEM_WB
);

    localparam int unsigned BYTE_PAD = DATA_W - 8;
    localparam int unsigned HALF_PAD = DATA_W - 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              misaligned_c;
    logic              accept_c;
    logic              drop_c;
    logic              capture_rdata_c;
    logic              mem_wb_en_c;
    logic [DATA_W-1:0] st_wdata_c;
    logic [3:0]        st_wstrb_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic [DATA_W-1:0] load_ext_c;

    logic [1:0]        addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] rdata_q;

    // Size decode from funct3[1:0]; the 11 encoding behaves as a word access.
    always_comb begin
        misaligned_c = 1'b0;
        st_wdata_c   = Read_data_2_EXE_MEM;
        st_wstrb_c   = 4'b1111;
        case (funct3_EXE_MEM[1:0])
            2'b00: begin
                st_wdata_c = {4{Read_data_2_EXE_MEM[7:0]}};
                st_wstrb_c = 4'b0001 << D_address[1:0];
            end
            2'b01: begin
                misaligned_c = D_address[0];
                st_wdata_c   = {2{Read_data_2_EXE_MEM[15:0]}};
                st_wstrb_c   = D_address[1] ? 4'b1100 : 4'b0011;
            end
            default: misaligned_c = (D_address[1:0] != 2'b00);
        endcase
    end

    assign accept_c    = (state == IDLE) && Dcache_en && !misaligned_c;
    assign drop_c      = (state == IDLE) && Dcache_en && misaligned_c;
    assign mem_wb_en_c = !(Istall || Dstall);

    // Next-state, stall and read-data capture decode.
    always_comb begin
        state_next      = state;
        Dstall          = 1'b0;
        capture_rdata_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = REQ;
                    Dstall     = 1'b1;
                end
            end
            REQ: begin
                Dstall = 1'b1;
                if (dc_gnt) begin
                    if (dc_ack) begin
                        state_next      = DONE;
                        capture_rdata_c = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                Dstall = 1'b1;
                if (dc_ack) begin
                    state_next      = DONE;
                    capture_rdata_c = 1'b1;
                end
            end
            DONE: begin
                if (!Istall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Extract and extend the load result from the latched word.
    always_comb begin
        case (addr_q)
            2'd1:    ld_byte_c = rdata_q[15:8];
            2'd2:    ld_byte_c = rdata_q[23:16];
            2'd3:    ld_byte_c = rdata_q[31:24];
            default: ld_byte_c = rdata_q[7:0];
        endcase
        ld_half_c = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q[1:0])
            2'b00: load_ext_c = funct3_q[2] ? {{BYTE_PAD{1'b0}}, ld_byte_c}
                                            : {{BYTE_PAD{ld_byte_c[7]}}, ld_byte_c};
            2'b01: load_ext_c = funct3_q[2] ? {{HALF_PAD{1'b0}}, ld_half_c}
                                            : {{HALF_PAD{ld_half_c[15]}}, ld_half_c};
            default: load_ext_c = rdata_q;
        endcase
    end

    // State, cache request, latched access and MEM/WB registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            dc_req            <= 1'b0;
            dc_write          <= 1'b0;
            dc_addr           <= '0;
            dc_wdata          <= '0;
            dc_wstrb          <= 4'b0000;
            misalign          <= 1'b0;
            addr_q            <= 2'b00;
            funct3_q          <= 3'b000;
            rdata_q           <= '0;
            wb_data_MEM_WB    <= '0;
            write_addr_MEM_WB <= 5'd0;
            WB_ctr_MEM_WB     <= 3'b000;
        end else begin
            state    <= state_next;
            dc_req   <= (state_next == REQ);
            misalign <= drop_c;
            if (accept_c) begin
                addr_q   <= D_address[1:0];
                funct3_q <= funct3_EXE_MEM;
                dc_write <= Dcache_write;
                dc_addr  <= {D_address[DATA_W-1:2], 2'b00};
                dc_wdata <= st_wdata_c;
                dc_wstrb <= Dcache_write ? st_wstrb_c : 4'b0000;
            end
            if (capture_rdata_c) rdata_q <= dc_rdata;
            if (mem_wb_en_c) begin
                wb_data_MEM_WB    <= WB_ctr_EXE_MEM[1] ? load_ext_c : alu_result_EXE_MEM;
                write_addr_MEM_WB <= write_addr_EXE_MEM;
                // A dropped misaligned access must not write the register file.
                WB_ctr_MEM_WB     <= {WB_ctr_EXE_MEM[2:1], WB_ctr_EXE_MEM[0] & ~drop_c};
            end
        end
    end

endmodule
